// File: rtl/cordic_pkg.sv
// cordic_pkg: shared constants, arctangent table, FSM states and angle clamp for the CORDIC core
package cordic_pkg;

    localparam int W = 18;
    localparam logic [W-1:0] K_INIT = 18'h09B75;
    localparam logic signed [7:0] ANGLE_MAX = 8'sd100;

    localparam logic [W-1:0] ATAN [16] = '{
        18'd51472, 18'd30386, 18'd16055, 18'd8150,
        18'd4091,  18'd2047,  18'd1024,  18'd512,
        18'd256,   18'd128,   18'd64,    18'd32,
        18'd16,    18'd8,     18'd4,     18'd2
    };

    typedef enum logic [1:0] {IDLE, ROT, DONE} state_t;

    // Keeps the rotation target inside the +/-pi/2 convergence range
    function automatic logic signed [7:0] clamp_angle(input logic signed [7:0] a);
        return (a > ANGLE_MAX) ? ANGLE_MAX : (a < -ANGLE_MAX) ? -ANGLE_MAX : a;
    endfunction

endpackage

// File: rtl/cordic_microrot.sv
// cordic_microrot: one combinational rotation-mode CORDIC step
import cordic_pkg::*;

module cordic_microrot (
    input  logic signed [W-1:0] x,
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] z,
    input  logic        [3:0]   sh,
    input  logic signed [W-1:0] atan,
    output logic signed [W-1:0] xn,
    output logic signed [W-1:0] yn,
    output logic signed [W-1:0] zn
);

    logic signed [W-1:0] xs, ys;
    logic pos;

    always_comb begin
        xs  = x >>> sh;
        ys  = y >>> sh;
        pos = ~z[W-1];
        xn  = pos ? x - ys : x + ys;
        yn  = pos ? y + xs : y - xs;
        zn  = pos ? z - atan : z + atan;
    end

endmodule

// File: rtl/cordic_iter_core.sv
// cordic_iter_core: iterative rotation-mode CORDIC producing Q1.16 cos/sin of an 8-bit angle
import cordic_pkg::*;

module cordic_iter_core #(
    parameter int ITER = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   angle_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] cos_out,
    output logic [W-1:0] sin_out
);

    state_t state, state_nxt;
    logic [4:0] cnt;
    logic signed [W-1:0] x, y, z, xn, yn, zn;
    logic last;

    cordic_microrot u_rot (
        .x    (x),
        .y    (y),
        .z    (z),
        .sh   (cnt[3:0]),
        .atan (ATAN[cnt[3:0]]),
        .xn   (xn),
        .yn   (yn),
        .zn   (zn)
    );

    // The cycle after the final micro-rotation registers the result
    always_comb begin
        last      = cnt == 5'(ITER);
        in_ready  = (state == IDLE) && rst_n;
        out_valid = state == DONE;
        state_nxt = state;
        if (state == IDLE && in_valid)
            state_nxt = ROT;
        else if (state == ROT && last)
            state_nxt = DONE;
        else if (state == DONE && out_ready)
            state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            x       <= '0;
            y       <= '0;
            z       <= '0;
            cos_out <= '0;
            sin_out <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && in_valid) begin
                cnt <= '0;
                x   <= K_INIT;
                y   <= '0;
                z   <= {clamp_angle(angle_in), 10'b0};
            end else if (state == ROT && last) begin
                cos_out <= x;
                sin_out <= y;
            end else if (state == ROT) begin
                cnt <= cnt + 5'd1;
                x   <= xn;
                y   <= yn;
                z   <= zn;
            end
        end
    end

endmodule

// File: tb/tb_cordic_iter_core.sv
// tb_cordic_iter_core: directed checks of latency, accuracy, clamping, backpressure and reset abort
module tb_cordic_iter_core;

    localparam int ITER = 16;

    logic        clk = 0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  angle_in;
    logic        out_valid;
    logic        out_ready;
    logic [17:0] cos_out;
    logic [17:0] sin_out;

    int checks = 0;
    int errors = 0;

    cordic_iter_core #(.ITER(ITER)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .angle_in  (angle_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .cos_out   (cos_out),
        .sin_out   (sin_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp, input int tol);
        checks++;
        if (got - exp > tol || exp - got > tol) begin
            errors++;
            $display("FAIL %s got %0d exp %0d tol %0d", tag, got, exp, tol);
        end
    endtask

    function automatic int sc(input logic [17:0] v);
        return int'($signed(v));
    endfunction

    // Downstream reduction to Q0.7 with rounding and saturation
    function automatic int round_off(input int v);
        int r;
        r = (v + 256) >>> 9;
        return (r > 127) ? 127 : (r < -128) ? -128 : r;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [7:0] a);
        int k = 0;
        while (!in_ready && k < 50) begin
            tick();
            k++;
        end
        check("rdy_wait", int'(in_ready), 1, 0);
        angle_in = a;
        in_valid = 1;
        tick();
        in_valid = 0;
    endtask

    task automatic wait_done(input string tag);
        int k = 0;
        while (!out_valid && k < 40) begin
            tick();
            k++;
        end
        check(tag, k, ITER + 1, 0);
    endtask

    task automatic run(input logic [7:0] a, input int ec, input int es, input int tol);
        go(a);
        wait_done("lat");
        check("cos", sc(cos_out), ec, tol);
        check("sin", sc(sin_out), es, tol);
        tick();
        check("ready_after", int'(in_ready), 1, 0);
        check("valid_after", int'(out_valid), 0, 0);
    endtask

    initial begin
        int c0, s0, n, k;
        rst_n = 0;
        in_valid = 0;
        out_ready = 1;
        angle_in = 0;
        repeat (2) tick();
        check("rst_ready_low", int'(in_ready), 0, 0);
        check("rst_valid", int'(out_valid), 0, 0);
        check("rst_cos", sc(cos_out), 0, 0);
        check("rst_sin", sc(sin_out), 0, 0);
        rst_n = 1;
        #1;
        check("rst_ready", int'(in_ready), 1, 0);

        run(8'h00, 65536, 0, 8);
        run(8'h32, 46525, 46157, 16);
        run(8'hCE, 46525, -46157, 16);
        run(8'h64, 544, 65534, 16);
        run(8'h7F, 544, 65534, 16);
        run(8'h80, 544, -65534, 16);
        run(8'h9C, 544, -65534, 16);

        out_ready = 0;
        go(8'h32);
        wait_done("hold_lat");
        c0 = sc(cos_out);
        s0 = sc(sin_out);
        check("hold_cos0", c0, 46525, 16);
        check("hold_sin0", s0, 46157, 16);
        for (int i = 0; i < 10; i++) begin
            in_valid = (i == 3);
            angle_in = 8'h00;
            tick();
            check("hold_valid", int'(out_valid), 1, 0);
            check("hold_ready", int'(in_ready), 0, 0);
            check("hold_cos", sc(cos_out), c0, 0);
            check("hold_sin", sc(sin_out), s0, 0);
        end
        in_valid = 0;
        out_ready = 1;
        tick();
        check("rel_ready", int'(in_ready), 1, 0);
        check("rel_valid", int'(out_valid), 0, 0);
        check("rel_cos", sc(cos_out), 46525, 16);

        go(8'h32);
        repeat (7) tick();
        rst_n = 0;
        #1;
        check("abort_ready_low", int'(in_ready), 0, 0);
        tick();
        rst_n = 1;
        #1;
        check("abort_ready", int'(in_ready), 1, 0);
        check("abort_valid", int'(out_valid), 0, 0);
        check("abort_cos", sc(cos_out), 0, 0);
        check("abort_sin", sc(sin_out), 0, 0);
        run(8'h00, 65536, 0, 8);

        in_valid = 1;
        angle_in = 8'h00;
        n = 0;
        k = 0;
        while (n < 3 && k < 80) begin
            tick();
            k++;
            if (out_valid) begin
                check("b2b_cos8", round_off(sc(cos_out)), 127, 0);
                check("b2b_sin8", round_off(sc(sin_out)), 0, 0);
                n++;
            end
        end
        in_valid = 0;
        check("b2b_count", n, 3, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
